mxu_input_skew: RTL and testbench

Sits between the RAM buffer's MXU-facing output and the systolic MXU array. It takes one 16-lane, 128-bit row beat per cycle and re-times it diagonally: lane k is delayed by k+1 cycles. The MXU therefore receives the wavefront skew it needs. The block also counts the row beats of one load command, drains the pipeline after the last row, and pulses `skew_done` when the last lane-15 byte reaches the MXU.

---
 rtl/mxu_input_skew_pkg.sv | 21 ++
 rtl/mxu_input_skew_lane_dly.sv | 41 ++++
 rtl/mxu_input_skew.sv | 168 ++++++++++++++++
 tb/tb_mxu_input_skew.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxu_input_skew_pkg.sv
// ---------------------------------------------------------------------------
// mxu_input_skew_pkg
// Shared constants and FSM encoding for the MXU input skew block.
//   LANE_NUM        lanes per row beat (one byte each)
//   LANE_WIDTH      bits per lane
//   SKEW_DRAIN_CYC  cycles spent in DRAIN after the last row beat
//   skew_fsm_e      IDLE / FILL / DRAIN state encoding
// ---------------------------------------------------------------------------
package mxu_input_skew_pkg;

  localparam int unsigned LANE_NUM       = 16;
  localparam int unsigned LANE_WIDTH     = 8;
  localparam int unsigned SKEW_DRAIN_CYC = LANE_NUM - 1;

  typedef enum logic [1:0] {
    SKEW_FSM_IDLE  = 2'b00,
    SKEW_FSM_FILL  = 2'b01,
    SKEW_FSM_DRAIN = 2'b10
  } skew_fsm_e;

endpackage

// File: rtl/mxu_input_skew_lane_dly.sv
// ---------------------------------------------------------------------------
// skew_lane_dly
// Fixed-depth delay line for one MXU lane: {valid, byte} shifts one stage
// every cycle. Synchronous active-low reset and synchronous clear both zero
// every stage; clear is used to flush in-flight data on a new command.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  synchronous active-low reset
//   i_clr    synchronous clear of all stages
//   i_din    {vld, data} entering the line
//   o_dout   {vld, data} after DEPTH cycles
// ---------------------------------------------------------------------------
module skew_lane_dly #(
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned LANE_WIDTH = mxu_input_skew_pkg::LANE_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic [LANE_WIDTH:0]   i_din,
  output logic [LANE_WIDTH:0]   o_dout
);

  logic [LANE_WIDTH:0] r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_dout = r_stage[DEPTH-1];

endmodule

// File: rtl/mxu_input_skew.sv
// ---------------------------------------------------------------------------
// mxu_input_skew
// Re-times 16-lane row beats from the RAM buffer into the diagonal wavefront
// the systolic MXU expects: lane k is delayed by k+1 cycles. Counts the rows
// of one load command, drains the pipeline after the last row and pulses
// skew_done when the last lane-15 byte reaches the MXU.
// Ports:
//   clk, rst_n          clock (rising edge) and synchronous active-low reset
//   ctrl_skew_vld       start of a new load command (restarts at any time)
//   ctrl_skew_row_num   rows in the command, 1..16 (0 behaves as 16)
//   ram_buff_mxu_vld    per-lane valid of the incoming row beat
//   ram_buff_mxu_data   incoming row, lane k in bits [8k+7:8k]
//   skew_mxu_vld        skewed per-lane valid to the MXU
//   skew_mxu_data       skewed data, zero on lanes whose valid is low
//   skew_busy           command in progress (FSM not IDLE)
//   skew_done           one-cycle pulse when the command has fully drained
//   skew_err            sticky: a beat arrived outside FILL
// ---------------------------------------------------------------------------
module mxu_input_skew #(
  parameter int unsigned LANE_NUM      = mxu_input_skew_pkg::LANE_NUM,
  parameter int unsigned LANE_WIDTH    = mxu_input_skew_pkg::LANE_WIDTH,
  parameter int unsigned ROW_CNT_WIDTH = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ctrl_skew_vld,
  input  logic [ROW_CNT_WIDTH-1:0]       ctrl_skew_row_num,
  input  logic [LANE_NUM-1:0]            ram_buff_mxu_vld,
  input  logic [LANE_NUM*LANE_WIDTH-1:0] ram_buff_mxu_data,
  output logic [LANE_NUM-1:0]            skew_mxu_vld,
  output logic [LANE_NUM*LANE_WIDTH-1:0] skew_mxu_data,
  output logic                           skew_busy,
  output logic                           skew_done,
  output logic                           skew_err
);

  import mxu_input_skew_pkg::skew_fsm_e;
  import mxu_input_skew_pkg::SKEW_FSM_IDLE;
  import mxu_input_skew_pkg::SKEW_FSM_FILL;
  import mxu_input_skew_pkg::SKEW_FSM_DRAIN;
  import mxu_input_skew_pkg::SKEW_DRAIN_CYC;

  localparam int unsigned DRAIN_W = (LANE_NUM > 1) ? $clog2(LANE_NUM) : 1;
  localparam logic [ROW_CNT_WIDTH-1:0] ROW_MAX = ROW_CNT_WIDTH'(1 << (ROW_CNT_WIDTH - 1));

  // ------------------------------------------------------------------------
  // Control state
  // ------------------------------------------------------------------------
  skew_fsm_e                r_state;
  logic [ROW_CNT_WIDTH-1:0] r_row_num;
  logic [ROW_CNT_WIDTH-1:0] r_row_cnt;
  logic [DRAIN_W-1:0]       r_drain_cnt;
  logic                     r_err;

  skew_fsm_e                w_state_nxt;
  logic [ROW_CNT_WIDTH-1:0] w_row_num_nxt;
  logic [ROW_CNT_WIDTH-1:0] w_row_cnt_nxt;
  logic [DRAIN_W-1:0]       w_drain_cnt_nxt;
  logic                     w_err_nxt;
  logic                     w_push;
  logic                     w_done;
  logic                     w_beat;
  logic [ROW_CNT_WIDTH-1:0] w_row_inc;
  logic [ROW_CNT_WIDTH-1:0] w_row_tgt;

  assign w_beat    = |ram_buff_mxu_vld;
  assign w_row_inc = r_row_cnt + ROW_CNT_WIDTH'(1);
  // A zero row count is latched as the maximum so the compare stays a plain
  // equality on the full counter width.
  assign w_row_tgt = (ctrl_skew_row_num == '0) ? ROW_MAX : ctrl_skew_row_num;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= SKEW_FSM_IDLE;
      r_row_num   <= '0;
      r_row_cnt   <= '0;
      r_drain_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row_num   <= w_row_num_nxt;
      r_row_cnt   <= w_row_cnt_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_err       <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_row_num_nxt   = r_row_num;
    w_row_cnt_nxt   = r_row_cnt;
    w_drain_cnt_nxt = r_drain_cnt;
    w_err_nxt       = r_err;
    w_push          = 1'b0;
    w_done          = 1'b0;

    if (ctrl_skew_vld) begin
      // A start overrides everything this cycle: same-cycle beat is dropped
      // and a coinciding drain completion does not raise skew_done.
      w_state_nxt     = SKEW_FSM_FILL;
      w_row_num_nxt   = w_row_tgt;
      w_row_cnt_nxt   = '0;
      w_drain_cnt_nxt = '0;
      w_err_nxt       = 1'b0;
    end else begin
      unique case (r_state)
        SKEW_FSM_IDLE: begin
          if (w_beat) w_err_nxt = 1'b1;
        end
        SKEW_FSM_FILL: begin
          if (w_beat) begin
            w_push        = 1'b1;
            w_row_cnt_nxt = w_row_inc;
            if (w_row_inc == r_row_num) begin
              w_state_nxt     = SKEW_FSM_DRAIN;
              w_drain_cnt_nxt = DRAIN_W'(SKEW_DRAIN_CYC);
            end
          end
        end
        SKEW_FSM_DRAIN: begin
          if (w_beat) w_err_nxt = 1'b1;
          if (r_drain_cnt == '0) begin
            w_done      = 1'b1;
            w_state_nxt = SKEW_FSM_IDLE;
          end else begin
            w_drain_cnt_nxt = r_drain_cnt - DRAIN_W'(1);
          end
        end
        default: begin
          w_state_nxt = SKEW_FSM_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------------
  // Lane delay lines: lane k has k+1 stages. Data is zeroed on entry when
  // its lane valid is low, so the final stage already carries masked data.
  // ------------------------------------------------------------------------
  for (genvar k = 0; k < LANE_NUM; k++) begin : g_lane
    logic                w_lane_vld;
    logic [LANE_WIDTH:0] w_din;
    logic [LANE_WIDTH:0] w_dout;

    assign w_lane_vld = w_push & ram_buff_mxu_vld[k];
    assign w_din      = {w_lane_vld,
                         w_lane_vld ? ram_buff_mxu_data[k*LANE_WIDTH +: LANE_WIDTH] : {LANE_WIDTH{1'b0}}};

    skew_lane_dly #(
      .DEPTH      (k + 1),
      .LANE_WIDTH (LANE_WIDTH)
    ) u_lane_dly (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_clr   (ctrl_skew_vld),
      .i_din   (w_din),
      .o_dout  (w_dout)
    );

    assign skew_mxu_vld[k]                              = w_dout[LANE_WIDTH];
    assign skew_mxu_data[k*LANE_WIDTH +: LANE_WIDTH]    = w_dout[LANE_WIDTH-1:0];
  end

  assign skew_busy = (r_state != SKEW_FSM_IDLE);
  assign skew_done = w_done;
  assign skew_err  = r_err;

endmodule

// File: tb/tb_mxu_input_skew.sv
// ---------------------------------------------------------------------------
// tb_mxu_input_skew
// Self-checking bench for mxu_input_skew. A reference model records which
// beats were accepted per cycle and derives every output from timing rules:
// lane k at cycle t shows the beat accepted at t-1-k unless a start happened
// since; done lands 16 cycles after the last row; busy spans start..done.
// ---------------------------------------------------------------------------
module tb_mxu_input_skew;

  localparam int MAXC = 4096;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ctrl_skew_vld;
  logic [4:0]   ctrl_skew_row_num;
  logic [15:0]  ram_buff_mxu_vld;
  logic [127:0] ram_buff_mxu_data;
  logic [15:0]  skew_mxu_vld;
  logic [127:0] skew_mxu_data;
  logic         skew_busy;
  logic         skew_done;
  logic         skew_err;

  always #5 clk = ~clk;

  mxu_input_skew #(
    .LANE_NUM      (16),
    .LANE_WIDTH    (8),
    .ROW_CNT_WIDTH (5)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ctrl_skew_vld     (ctrl_skew_vld),
    .ctrl_skew_row_num (ctrl_skew_row_num),
    .ram_buff_mxu_vld  (ram_buff_mxu_vld),
    .ram_buff_mxu_data (ram_buff_mxu_data),
    .skew_mxu_vld      (skew_mxu_vld),
    .skew_mxu_data     (skew_mxu_data),
    .skew_busy         (skew_busy),
    .skew_done         (skew_done),
    .skew_err          (skew_err)
  );

  typedef struct {
    logic         c;
    logic [4:0]   rn;
    logic [15:0]  v;
    logic [127:0] d;
  } stim_t;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int           cyc;
  int           last_clr;
  bit           m_act;
  int           m_rows;
  int           m_got;
  int           m_last;
  bit           m_err;
  logic [15:0]  h_vld [MAXC];
  logic [127:0] h_dat [MAXC];

  logic [15:0]  exp_vld;
  logic [127:0] exp_data;
  logic         exp_busy;
  logic         exp_done;
  logic         exp_err;

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic stim_t mk(input logic c, input int rn, input logic [15:0] v, input logic [127:0] d);
    stim_t s;
    s.c  = c;
    s.rn = 5'(rn);
    s.v  = v;
    s.d  = d;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(1'b0, $urandom_range(1, 16), 16'h0000, rand128());
  endfunction

  // Apply one cycle of stimulus and compute the model's expectation for the
  // outputs visible during this cycle.
  task automatic drive(input stim_t s);
    ctrl_skew_vld     = s.c;
    ctrl_skew_row_num = s.rn;
    ram_buff_mxu_vld  = s.v;
    ram_buff_mxu_data = s.d;
    #3;
    exp_vld  = '0;
    exp_data = '0;
    for (int k = 0; k < 16; k++) begin
      int src;
      src = cyc - 1 - k;
      if (src >= 0 && src > last_clr && h_vld[src][k]) begin
        exp_vld[k]         = 1'b1;
        exp_data[8*k +: 8] = h_dat[src][8*k +: 8];
      end
    end
    exp_busy = m_act && (m_last < 0 || cyc <= m_last + 16);
    exp_done = m_act && m_last >= 0 && cyc == m_last + 16 && !s.c;
    exp_err  = m_err;
  endtask

  // Fold this cycle's inputs into the model and move to the next cycle.
  task automatic advance(input stim_t s);
    h_vld[cyc] = '0;
    h_dat[cyc] = '0;
    if (s.c) begin
      m_act    = 1'b1;
      m_rows   = (s.rn == 5'd0) ? 16 : int'(s.rn);
      m_got    = 0;
      m_last   = -1;
      m_err    = 1'b0;
      last_clr = cyc;
    end else begin
      if (m_act && m_last >= 0 && cyc >= m_last + 16) m_act = 1'b0;
      if (|s.v) begin
        if (m_act && m_last < 0) begin
          h_vld[cyc] = s.v;
          h_dat[cyc] = s.d;
          m_got++;
          if (m_got == m_rows) m_last = cyc;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d required below %0d", cyc, MAXC);
      $fatal(1);
    end
  endtask

  task automatic test_reset();
    stim_t q[$];
    for (int i = 0; i < 20; i++) q.push_back(idle());
    foreach (q[i]) begin
      drive(q[i]);
      n_cmp++;
      if ({skew_mxu_vld, skew_mxu_data} !== {exp_vld, exp_data}) begin
        n_bad++;
        $display("FAIL reset_data cyc=%0d got vld=%h data=%h exp vld=%h data=%h", cyc, skew_mxu_vld, skew_mxu_data, exp_vld, exp_data);
      end
      n_cmp++;
      if ({skew_busy, skew_done, skew_err} !== {exp_busy, exp_done, exp_err}) begin
        n_bad++;
        $display("FAIL reset_ctrl cyc=%0d got busy/done/err=%b%b%b exp=%b%b%b", cyc, skew_busy, skew_done, skew_err, exp_busy, exp_done, exp_err);
      end
      advance(q[i]);
    end
  endtask

  task automatic test_single_row();
    stim_t q[$];
    logic [127:0] d;
    for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(k);
    q.push_back(mk(1'b1, 1, 16'h0000, rand128()));
    q.push_back(mk(1'b0, 1, 16'hFFFF, d));
    for (int i = 0; i < 20; i++) q.push_back(idle());
    foreach (q[i]) begin
      drive(q[i]);
      n_cmp++;
      if ({skew_mxu_vld, skew_mxu_data} !== {exp_vld, exp_data}) begin
        n_bad++;
        $display("FAIL single_data cyc=%0d got vld=%h data=%h exp vld=%h data=%h", cyc, skew_mxu_vld, skew_mxu_data, exp_vld, exp_data);
      end
      n_cmp++;
      if ({skew_busy, skew_done, skew_err} !== {exp_busy, exp_done, exp_err}) begin
        n_bad++;
        $display("FAIL single_ctrl cyc=%0d got busy/done/err=%b%b%b exp=%b%b%b", cyc, skew_busy, skew_done, skew_err, exp_busy, exp_done, exp_err);
      end
      advance(q[i]);
    end
  endtask

  task automatic test_back_to_back();
    stim_t q[$];
    q.push_back(mk(1'b1, 16, 16'h0000, rand128()));
    for (int r = 0; r < 16; r++) q.push_back(mk(1'b0, 16, 16'hFFFF, {16{8'(r)}}));
    for (int i = 0; i < 20; i++) q.push_back(idle());
    foreach (q[i]) begin
      drive(q[i]);
      n_cmp++;
      if ({skew_mxu_vld, skew_mxu_data} !== {exp_vld, exp_data}) begin
        n_bad++;
        $display("FAIL b2b_data cyc=%0d got vld=%h data=%h exp vld=%h data=%h", cyc, skew_mxu_vld, skew_mxu_data, exp_vld, exp_data);
      end
      n_cmp++;
      if ({skew_busy, skew_done, skew_err} !== {exp_busy, exp_done, exp_err}) begin
        n_bad++;
        $display("FAIL b2b_ctrl cyc=%0d got busy/done/err=%b%b%b exp=%b%b%b", cyc, skew_busy, skew_done, skew_err, exp_busy, exp_done, exp_err);
      end
      advance(q[i]);
    end
  endtask

  task automatic test_partial_vld();
    stim_t q[$];
    q.push_back(mk(1'b1, 2, 16'h0000, rand128()));
    q.push_back(mk(1'b0, 2, 16'h00F0, {16{8'hAA}}));
    q.push_back(mk(1'b0, 2, 16'($urandom()) | 16'h8001, rand128()));
    for (int i = 0; i < 20; i++) q.push_back(idle());
    foreach (q[i]) begin
      drive(q[i]);
      n_cmp++;
      if ({skew_mxu_vld, skew_mxu_data} !== {exp_vld, exp_data}) begin
        n_bad++;
        $display("FAIL partial_data cyc=%0d got vld=%h data=%h exp vld=%h data=%h", cyc, skew_mxu_vld, skew_mxu_data, exp_vld, exp_data);
      end
      n_cmp++;
      if ({skew_busy, skew_done, skew_err} !== {exp_busy, exp_done, exp_err}) begin
        n_bad++;
        $display("FAIL partial_ctrl cyc=%0d got busy/done/err=%b%b%b exp=%b%b%b", cyc, skew_busy, skew_done, skew_err, exp_busy, exp_done, exp_err);
      end
      advance(q[i]);
    end
  endtask

  task automatic test_err();
    stim_t q[$];
    q.push_back(mk(1'b0, 1, 16'hFFFF, rand128()));          // beat in IDLE
    for (int i = 0; i < 3; i++) q.push_back(idle());
    q.push_back(mk(1'b1, 1, 16'h0000, rand128()));          // start clears err
    q.push_back(mk(1'b0, 1, 16'hFFFF, rand128()));          // only row
    for (int i = 0; i < 3; i++) q.push_back(idle());
    q.push_back(mk(1'b0, 1, 16'h3C3C, rand128()));          // beat in DRAIN
    for (int i = 0; i < 20; i++) q.push_back(idle());
    q.push_back(mk(1'b1, 2, 16'hFFFF, rand128()));          // start, same-cycle beat dropped
    q.push_back(mk(1'b0, 2, 16'hFFFF, rand128()));
    q.push_back(mk(1'b0, 2, 16'h0FF0, rand128()));
    for (int i = 0; i < 20; i++) q.push_back(idle());
    foreach (q[i]) begin
      drive(q[i]);
      n_cmp++;
      if ({skew_mxu_vld, skew_mxu_data} !== {exp_vld, exp_data}) begin
        n_bad++;
        $display("FAIL err_data cyc=%0d got vld=%h data=%h exp vld=%h data=%h", cyc, skew_mxu_vld, skew_mxu_data, exp_vld, exp_data);
      end
      n_cmp++;
      if ({skew_busy, skew_done, skew_err} !== {exp_busy, exp_done, exp_err}) begin
        n_bad++;
        $display("FAIL err_ctrl cyc=%0d got busy/done/err=%b%b%b exp=%b%b%b", cyc, skew_busy, skew_done, skew_err, exp_busy, exp_done, exp_err);
      end
      advance(q[i]);
    end
  endtask

  task automatic test_restart();
    stim_t q[$];
    q.push_back(mk(1'b1, 4, 16'h0000, rand128()));
    q.push_back(mk(1'b0, 4, 16'hFFFF, rand128()));
    q.push_back(mk(1'b0, 4, 16'hFFFF, rand128()));
    q.push_back(mk(1'b1, 4, 16'h0000, rand128()));          // restart mid-FILL
    for (int i = 0; i < 4; i++) q.push_back(mk(1'b0, 4, 16'hFFFF, rand128()));
    for (int i = 0; i < 20; i++) q.push_back(idle());
    foreach (q[i]) begin
      drive(q[i]);
      n_cmp++;
      if ({skew_mxu_vld, skew_mxu_data} !== {exp_vld, exp_data}) begin
        n_bad++;
        $display("FAIL restart_data cyc=%0d got vld=%h data=%h exp vld=%h data=%h", cyc, skew_mxu_vld, skew_mxu_data, exp_vld, exp_data);
      end
      n_cmp++;
      if ({skew_busy, skew_done, skew_err} !== {exp_busy, exp_done, exp_err}) begin
        n_bad++;
        $display("FAIL restart_ctrl cyc=%0d got busy/done/err=%b%b%b exp=%b%b%b", cyc, skew_busy, skew_done, skew_err, exp_busy, exp_done, exp_err);
      end
      advance(q[i]);
    end
  endtask

  task automatic test_start_at_done();
    stim_t q[$];
    q.push_back(mk(1'b1, 1, 16'h0000, rand128()));
    q.push_back(mk(1'b0, 1, 16'hFFFF, rand128()));          // last beat at T
    for (int i = 0; i < 15; i++) q.push_back(idle());       // T+1 .. T+15
    q.push_back(mk(1'b1, 3, 16'h0000, rand128()));          // start at T+16
    for (int i = 0; i < 3; i++) q.push_back(mk(1'b0, 3, 16'($urandom()) | 16'h0001, rand128()));
    for (int i = 0; i < 20; i++) q.push_back(idle());
    foreach (q[i]) begin
      drive(q[i]);
      n_cmp++;
      if ({skew_mxu_vld, skew_mxu_data} !== {exp_vld, exp_data}) begin
        n_bad++;
        $display("FAIL startdone_data cyc=%0d got vld=%h data=%h exp vld=%h data=%h", cyc, skew_mxu_vld, skew_mxu_data, exp_vld, exp_data);
      end
      n_cmp++;
      if ({skew_busy, skew_done, skew_err} !== {exp_busy, exp_done, exp_err}) begin
        n_bad++;
        $display("FAIL startdone_ctrl cyc=%0d got busy/done/err=%b%b%b exp=%b%b%b", cyc, skew_busy, skew_done, skew_err, exp_busy, exp_done, exp_err);
      end
      advance(q[i]);
    end
  endtask

  task automatic test_random();
    stim_t q[$];
    for (int i = 0; i < 400; i++) begin
      logic        c;
      logic [15:0] v;
      c = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 9) < 6) ? 16'($urandom()) : 16'h0000;
      q.push_back(mk(c, $urandom_range(1, 16), v, rand128()));
    end
    for (int i = 0; i < 20; i++) q.push_back(idle());
    foreach (q[i]) begin
      drive(q[i]);
      n_cmp++;
      if ({skew_mxu_vld, skew_mxu_data} !== {exp_vld, exp_data}) begin
        n_bad++;
        $display("FAIL random_data cyc=%0d got vld=%h data=%h exp vld=%h data=%h", cyc, skew_mxu_vld, skew_mxu_data, exp_vld, exp_data);
      end
      n_cmp++;
      if ({skew_busy, skew_done, skew_err} !== {exp_busy, exp_done, exp_err}) begin
        n_bad++;
        $display("FAIL random_ctrl cyc=%0d got busy/done/err=%b%b%b exp=%b%b%b", cyc, skew_busy, skew_done, skew_err, exp_busy, exp_done, exp_err);
      end
      advance(q[i]);
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    ctrl_skew_vld     = 1'b0;
    ctrl_skew_row_num = 5'd1;
    ram_buff_mxu_vld  = '0;
    ram_buff_mxu_data = '0;
    for (int i = 0; i < MAXC; i++) begin
      h_vld[i] = '0;
      h_dat[i] = '0;
    end
    cyc      = 0;
    last_clr = -1;
    m_act    = 1'b0;
    m_rows   = 1;
    m_got    = 0;
    m_last   = -1;
    m_err    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    test_reset();
    test_single_row();
    test_back_to_back();
    test_partial_vld();
    test_err();
    test_restart();
    test_start_at_done();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
